// File: rtl/lector_rtc_pkg.sv
// -----------------------------------------------------------------------------
// lector_rtc_pkg
// Shared definitions for the RTC read sequencer and its address table:
//   - RTC register addresses, including the transfer command address
//   - sequencer state encoding
//   - transaction counts: one command followed by nine register reads
// -----------------------------------------------------------------------------
package lector_rtc_pkg;

    // Command transaction: the RTC latches its counters into the readable
    // registers when this address/data pair is written.
    localparam logic [7:0] ADDR_CMD    = 8'hF0;

    localparam logic [7:0] ADDR_SEG    = 8'h21;
    localparam logic [7:0] ADDR_MIN    = 8'h22;
    localparam logic [7:0] ADDR_HORA   = 8'h23;
    localparam logic [7:0] ADDR_DAY    = 8'h24;
    localparam logic [7:0] ADDR_MONTH  = 8'h25;
    localparam logic [7:0] ADDR_YEAR   = 8'h26;
    localparam logic [7:0] ADDR_SEG_T  = 8'h42;
    localparam logic [7:0] ADDR_MIN_T  = 8'h41;
    localparam logic [7:0] ADDR_HORA_T = 8'h43;

    localparam int N_TRANS = 10;
    localparam int N_DATOS = 9;

    // Index of the last transaction of a sequence.
    localparam logic [3:0] ULTIMO_IDX = 4'(N_TRANS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } estado_t;

endpackage

// File: rtl/lector_rtc_if.sv
// -----------------------------------------------------------------------------
// lector_rtc_if
// Request/acknowledge bus between a sequencer (master) and the RTC bus-cycle
// controller (slave).
//   bus_req  : transaction request level, held until bus_ack or abort
//   bus_wr   : 1 = write, 0 = read; stable while bus_req = 1
//   bus_addr : RTC register address; stable while bus_req = 1
//   bus_dout : write data
//   bus_ack  : one-cycle pulse, transaction finished
//   Data_RD  : read data, valid in the bus_ack cycle of a read
// -----------------------------------------------------------------------------
interface lector_rtc_if;
    logic       bus_req;
    logic       bus_wr;
    logic [7:0] bus_addr;
    logic [7:0] bus_dout;
    logic       bus_ack;
    logic [7:0] Data_RD;

    modport master (
        output bus_req,
        output bus_wr,
        output bus_addr,
        output bus_dout,
        input  bus_ack,
        input  Data_RD
    );

    modport slave (
        input  bus_req,
        input  bus_wr,
        input  bus_addr,
        input  bus_dout,
        output bus_ack,
        output Data_RD
    );
endinterface

// File: rtl/lector_rtc_tabla_dir_rtc.sv
// -----------------------------------------------------------------------------
// tabla_dir_rtc
// Combinational lookup from transaction index to bus attributes.
// The programming path uses the same table.
//   idx      in  4  transaction index (0 = command, 1..9 = register reads)
//   bus_wr   out 1  1 only for the command transaction
//   bus_addr out 8  RTC register address
//   bus_dout out 8  ADDR_CMD for the command, 0 for reads
// -----------------------------------------------------------------------------
module tabla_dir_rtc #(
    parameter logic [7:0] ADDR_CMD = lector_rtc_pkg::ADDR_CMD
) (
    input  logic [3:0] idx,
    output logic       bus_wr,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_dout
);
    import lector_rtc_pkg::*;

    // Index decode; indices outside 0..9 map to a harmless read of address 0.
    always_comb begin
        bus_wr   = 1'b0;
        bus_addr = 8'h00;
        bus_dout = 8'h00;
        case (idx)
            4'd0: begin
                bus_wr   = 1'b1;
                bus_addr = ADDR_CMD;
                bus_dout = ADDR_CMD;
            end
            4'd1:    bus_addr = ADDR_SEG;
            4'd2:    bus_addr = ADDR_MIN;
            4'd3:    bus_addr = ADDR_HORA;
            4'd4:    bus_addr = ADDR_DAY;
            4'd5:    bus_addr = ADDR_MONTH;
            4'd6:    bus_addr = ADDR_YEAR;
            4'd7:    bus_addr = ADDR_SEG_T;
            4'd8:    bus_addr = ADDR_MIN_T;
            4'd9:    bus_addr = ADDR_HORA_T;
            default: bus_addr = 8'h00;
        endcase
    end
endmodule

// File: rtl/lector_rtc.sv
// -----------------------------------------------------------------------------
// lector_rtc
// Read-side sequencer for the RTC parallel bus. On iniciar it:
//   1. writes the transfer command,
//   2. reads the nine time/date/timer registers into a shadow buffer,
//   3. commits all nine bytes to the outputs together.
// A per-transaction timeout aborts the sequence if the bus controller hangs.
// The committed outputs then keep their previous values.
//   clk, reset        clock, asynchronous active-high reset
//   iniciar           start pulse, accepted only in IDLE
//   bus               master side of the RTC bus
//   seg..hora_t       committed raw BCD register values
//   ocupado           sequence in progress
//   lectura_lista     one-cycle pulse when new values are committed
//   error_to          sticky timeout flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module lector_rtc #(
    parameter int         TIMEOUT_CICLOS = 255,
    parameter logic [7:0] ADDR_CMD       = lector_rtc_pkg::ADDR_CMD
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          iniciar,
    lector_rtc_if.master  bus,
    output logic [7:0]    seg,
    output logic [7:0]    min,
    output logic [7:0]    hora,
    output logic [7:0]    day,
    output logic [7:0]    month,
    output logic [7:0]    year,
    output logic [7:0]    seg_t,
    output logic [7:0]    min_t,
    output logic [7:0]    hora_t,
    output logic          ocupado,
    output logic          lectura_lista,
    output logic          error_to
);
    import lector_rtc_pkg::*;

    // The timer counts REQ cycles without ack. It is compared against the
    // last allowed value, so a transaction gets TIMEOUT_CICLOS REQ cycles.
    localparam logic [7:0] TIMER_LIM = 8'(TIMEOUT_CICLOS - 1);

    estado_t                   state_q, state_d;
    logic [3:0]                index_q, index_d;
    logic [7:0]                timer_q, timer_d;
    logic [N_DATOS-1:0][7:0]   shadow_q, shadow_d;
    logic [N_DATOS-1:0][7:0]   valores_q, valores_d;
    logic                      error_to_q, error_to_d;

    logic                      bus_req_q, bus_req_d;
    logic                      bus_wr_q, bus_wr_d;
    logic [7:0]                bus_addr_q, bus_addr_d;
    logic [7:0]                bus_dout_q, bus_dout_d;
    logic                      ocupado_q, ocupado_d;
    logic                      lectura_lista_q, lectura_lista_d;

    logic                      tab_wr;
    logic [7:0]                tab_addr;
    logic [7:0]                tab_dout;

    // The table is indexed with the next index, so the registered bus
    // attributes are valid in the first REQ cycle of each transaction.
    tabla_dir_rtc #(
        .ADDR_CMD (ADDR_CMD)
    ) u_tabla (
        .idx      (index_d),
        .bus_wr   (tab_wr),
        .bus_addr (tab_addr),
        .bus_dout (tab_dout)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update: index, timeout timer, shadow capture, commit.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        timer_d    = timer_q;
        shadow_d   = shadow_q;
        valores_d  = valores_q;
        error_to_d = error_to_q;
        case (state_q)
            ST_IDLE: begin
                if (iniciar) begin
                    state_d    = ST_REQ;
                    index_d    = 4'd0;
                    timer_d    = 8'd0;
                    shadow_d   = '0;
                    error_to_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // An ack in the timeout cycle still counts as success.
                if (bus.bus_ack) begin
                    if (index_q != 4'd0) begin
                        shadow_d[index_q - 4'd1] = bus.Data_RD;
                    end else begin
                        shadow_d = shadow_q;
                    end
                    timer_d = 8'd0;
                    state_d = ST_GAP;
                end else if (timer_q == TIMER_LIM) begin
                    error_to_d = 1'b1;
                    timer_d    = 8'd0;
                    index_d    = 4'd0;
                    state_d    = ST_IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (index_q == ULTIMO_IDX) begin
                    valores_d = shadow_q;
                    state_d   = ST_DONE;
                end else begin
                    index_d = index_q + 4'd1;
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the flopped outputs line up with the state.
    always_comb begin
        bus_req_d       = (state_d == ST_REQ);
        ocupado_d       = (state_d != ST_IDLE);
        lectura_lista_d = (state_d == ST_DONE);
        if (state_d == ST_REQ) begin
            bus_wr_d   = tab_wr;
            bus_addr_d = tab_addr;
            bus_dout_d = tab_dout;
        end else begin
            bus_wr_d   = 1'b0;
            bus_addr_d = 8'h00;
            bus_dout_d = 8'h00;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_q         <= 4'd0;
            timer_q         <= 8'd0;
            shadow_q        <= '0;
            valores_q       <= '0;
            error_to_q      <= 1'b0;
            bus_req_q       <= 1'b0;
            bus_wr_q        <= 1'b0;
            bus_addr_q      <= 8'h00;
            bus_dout_q      <= 8'h00;
            ocupado_q       <= 1'b0;
            lectura_lista_q <= 1'b0;
        end else begin
            index_q         <= index_d;
            timer_q         <= timer_d;
            shadow_q        <= shadow_d;
            valores_q       <= valores_d;
            error_to_q      <= error_to_d;
            bus_req_q       <= bus_req_d;
            bus_wr_q        <= bus_wr_d;
            bus_addr_q      <= bus_addr_d;
            bus_dout_q      <= bus_dout_d;
            ocupado_q       <= ocupado_d;
            lectura_lista_q <= lectura_lista_d;
        end
    end

    assign bus.bus_req    = bus_req_q;
    assign bus.bus_wr     = bus_wr_q;
    assign bus.bus_addr   = bus_addr_q;
    assign bus.bus_dout   = bus_dout_q;

    assign seg            = valores_q[0];
    assign min            = valores_q[1];
    assign hora           = valores_q[2];
    assign day            = valores_q[3];
    assign month          = valores_q[4];
    assign year           = valores_q[5];
    assign seg_t          = valores_q[6];
    assign min_t          = valores_q[7];
    assign hora_t         = valores_q[8];
    assign ocupado        = ocupado_q;
    assign lectura_lista  = lectura_lista_q;
    assign error_to       = error_to_q;
endmodule

// File: tb/tb_lector_rtc.sv
// -----------------------------------------------------------------------------
// tb_lector_rtc
// Bench for lector_rtc. A behavioural bus-controller model acks each
// transaction after a chosen latency and supplies read data. Expected results
// come from the documented rules:
//   - fixed address order
//   - L+2 cycles per transaction
//   - commit only after a complete sequence
//   - timeout after TIMEOUT_CICLOS REQ cycles
// -----------------------------------------------------------------------------
module tb_lector_rtc;

    localparam int TO = 8;
    localparam logic [7:0] EXP_ADDR [10] = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24,
                                             8'h25, 8'h26, 8'h42, 8'h41, 8'h43};

    logic clk;
    logic reset;
    logic iniciar;
    logic [7:0] seg, min, hora, day, month, year, seg_t, min_t, hora_t;
    logic ocupado, lectura_lista, error_to;

    lector_rtc_if bus_if ();

    lector_rtc #(.TIMEOUT_CICLOS(TO), .ADDR_CMD(8'hF0)) dut (
        .clk           (clk),
        .reset         (reset),
        .iniciar       (iniciar),
        .bus           (bus_if.master),
        .seg           (seg),
        .min           (min),
        .hora          (hora),
        .day           (day),
        .month         (month),
        .year          (year),
        .seg_t         (seg_t),
        .min_t         (min_t),
        .hora_t        (hora_t),
        .ocupado       (ocupado),
        .lectura_lista (lectura_lista),
        .error_to      (error_to)
    );

    wire [8:0][7:0] outv = {hora_t, min_t, seg_t, year, month, day, hora, min, seg};

    int n_checks = 0;
    int n_fail   = 0;

    // Scenario description and model state.
    int         lat_a [10];
    logic [7:0] dat_a [9];
    logic [7:0] model_out [9];

    // Observations from one sequence.
    logic [7:0] obs_addr [$];
    logic       obs_wr   [$];
    logic [7:0] obs_dout [$];
    int         obs_len  [$];
    int         done_cycle, done_count, unstable, err_c1, cycles;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse iniciar, act as the bus controller, and record what the DUT does.
    // stall_idx never gets an ack. poke adds stray starts and acks.
    task automatic run_seq(input int stall_idx, input bit poke);
        int reqlen;
        int tr;
        bit fin;
        obs_addr.delete(); obs_wr.delete(); obs_dout.delete(); obs_len.delete();
        done_cycle = -1; done_count = 0; unstable = 0; err_c1 = -1; cycles = 0;
        reqlen = 0; fin = 1'b0;
        iniciar = 1'b1;
        while (!fin) begin
            @(posedge clk); #1;
            cycles++;
            iniciar = 1'b0; bus_if.bus_ack = 1'b0; bus_if.Data_RD = 8'h00;
            if (cycles == 1) err_c1 = int'(error_to);
            if (bus_if.bus_req) begin
                if (reqlen == 0) begin
                    obs_addr.push_back(bus_if.bus_addr);
                    obs_wr.push_back(bus_if.bus_wr);
                    obs_dout.push_back(bus_if.bus_dout);
                end else if (bus_if.bus_addr !== obs_addr[$] || bus_if.bus_wr !== obs_wr[$]) begin
                    unstable++;
                end
                reqlen++;
                tr = obs_addr.size() - 1;
                if (tr < 10 && tr != stall_idx && reqlen == lat_a[tr] + 1) begin
                    bus_if.bus_ack = 1'b1;
                    if (tr > 0) bus_if.Data_RD = dat_a[tr-1];
                end
            end else begin
                if (reqlen != 0) begin
                    obs_len.push_back(reqlen);
                    reqlen = 0;
                end
                if (poke && ocupado) begin
                    bus_if.bus_ack = 1'b1;
                    bus_if.Data_RD = 8'hEE;
                end
            end
            if (lectura_lista) begin
                done_count++;
                if (done_cycle < 0) done_cycle = cycles;
            end
            if (poke && (cycles == 3 || cycles == 6 || lectura_lista)) iniciar = 1'b1;
            if (!ocupado) fin = 1'b1;
            if (cycles >= 1500) begin
                n_checks++; n_fail++;
                $display("FAIL seq_budget: sequence still busy after %0d cycles, required to end", cycles);
                fin = 1'b1;
            end
        end
        iniciar = 1'b0; bus_if.bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus_if.bus_req, ocupado, lectura_lista, error_to} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: req/ocup/lista/err=%b required 0000",
                     {bus_if.bus_req, ocupado, lectura_lista, error_to});
        end
        n_checks++;
        if (outv !== 72'h0) begin
            n_fail++; $display("FAIL reset_values: got %h required 0", outv);
        end
        n_checks++;
        if ({bus_if.bus_addr, bus_if.bus_dout, bus_if.bus_wr} !== 17'h0) begin
            n_fail++; $display("FAIL reset_bus: addr %h dout %h wr %b required 0",
                               bus_if.bus_addr, bus_if.bus_dout, bus_if.bus_wr);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ocupado !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: ocupado %b required 0", ocupado);
        end
        for (int i = 0; i < 9; i++) model_out[i] = 8'h00;
    endtask

    task automatic test_normal_read();
        for (int i = 0; i < 10; i++) lat_a[i] = 0;
        for (int i = 0; i < 9; i++) dat_a[i] = 8'((i + 1) * 17);
        run_seq(-1, 1'b0);
        n_checks++;
        if (obs_addr.size() !== 10) begin
            n_fail++; $display("FAIL normal_count: %0d transactions required 10", obs_addr.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (obs_addr[i] !== EXP_ADDR[i] || obs_wr[i] !== (i == 0) ||
                    obs_dout[i] !== ((i == 0) ? 8'hF0 : 8'h00)) begin
                    n_fail++;
                    $display("FAIL normal_trans%0d: addr %h wr %b dout %h required %h %b %h", i,
                             obs_addr[i], obs_wr[i], obs_dout[i], EXP_ADDR[i], (i == 0),
                             (i == 0) ? 8'hF0 : 8'h00);
                end
            end
        end
        n_checks++;
        if (done_cycle !== 21 || done_count !== 1) begin
            n_fail++; $display("FAIL normal_lista: cycle %0d count %0d required 21 1", done_cycle, done_count);
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (outv[i] !== dat_a[i]) begin
                n_fail++; $display("FAIL normal_val%0d: got %h required %h", i, outv[i], dat_a[i]);
            end
            model_out[i] = dat_a[i];
        end
    endtask

    task automatic test_stalled_ack();
        int exp_done;
        exp_done = 1;
        for (int i = 0; i < 10; i++) begin lat_a[i] = 5; exp_done += lat_a[i] + 2; end
        for (int i = 0; i < 9; i++) dat_a[i] = 8'($urandom);
        run_seq(-1, 1'b0);
        n_checks++;
        if (done_cycle !== 71 || done_cycle !== exp_done) begin
            n_fail++; $display("FAIL stall_lista: cycle %0d required 71", done_cycle);
        end
        n_checks++;
        if (unstable !== 0) begin
            n_fail++; $display("FAIL stall_stable: %0d address changes during req, required 0", unstable);
        end
        n_checks++;
        if (obs_len.size() !== 10) begin
            n_fail++; $display("FAIL stall_count: %0d req bursts required 10", obs_len.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (obs_len[i] !== 6) begin
                    n_fail++; $display("FAIL stall_len%0d: req high %0d cycles required 6", i, obs_len[i]);
                end
            end
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (outv[i] !== dat_a[i]) begin
                n_fail++; $display("FAIL stall_val%0d: got %h required %h", i, outv[i], dat_a[i]);
            end
            model_out[i] = dat_a[i];
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 10; i++) lat_a[i] = int'($urandom_range(0, 3));
        for (int i = 0; i < 9; i++) dat_a[i] = 8'($urandom);
        dat_a[0] = 8'h30;
        run_seq(-1, 1'b0);
        n_checks++;
        if (seg !== 8'h30 || done_count !== 1) begin
            n_fail++; $display("FAIL to_prep: seg %h count %0d required 30 1", seg, done_count);
        end
        for (int i = 0; i < 9; i++) model_out[i] = dat_a[i];
        // Fresh data that must never become visible.
        for (int i = 0; i < 9; i++) dat_a[i] = 8'($urandom);
        run_seq(4, 1'b0);
        n_checks++;
        if (obs_len.size() !== 5 || obs_len[obs_len.size()-1] !== TO) begin
            n_fail++; $display("FAIL to_drop: %0d bursts, last %0d cycles required 5 bursts, last %0d",
                               obs_len.size(), (obs_len.size() > 0) ? obs_len[obs_len.size()-1] : -1, TO);
        end
        n_checks++;
        if (error_to !== 1'b1 || done_count !== 0) begin
            n_fail++; $display("FAIL to_flag: error_to %b lista %0d required 1 0", error_to, done_count);
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (outv[i] !== model_out[i]) begin
                n_fail++; $display("FAIL to_keep%0d: got %h required %h", i, outv[i], model_out[i]);
            end
        end
        // A new start clears the flag from its first busy cycle.
        for (int i = 0; i < 9; i++) dat_a[i] = 8'($urandom);
        run_seq(-1, 1'b0);
        n_checks++;
        if (err_c1 !== 0 || error_to !== 1'b0 || done_count !== 1) begin
            n_fail++; $display("FAIL to_clear: err@1 %0d err %b lista %0d required 0 0 1",
                               err_c1, error_to, done_count);
        end
        for (int i = 0; i < 9; i++) model_out[i] = dat_a[i];
    endtask

    task automatic test_ignored_start();
        for (int i = 0; i < 10; i++) lat_a[i] = 0;
        for (int i = 0; i < 9; i++) dat_a[i] = 8'($urandom_range(0, 200));
        run_seq(-1, 1'b1);
        n_checks++;
        if (obs_addr.size() !== 10 || done_count !== 1 || done_cycle !== 21) begin
            n_fail++; $display("FAIL ign_seq: %0d trans, lista %0d at %0d required 10 1 21",
                               obs_addr.size(), done_count, done_cycle);
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (obs_addr[i] !== EXP_ADDR[i]) begin
                    n_fail++; $display("FAIL ign_addr%0d: got %h required %h", i, obs_addr[i], EXP_ADDR[i]);
                end
            end
        end
        begin
            int bad;
            bad = 0;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                if (ocupado !== 1'b0 || lectura_lista !== 1'b0 || bus_if.bus_req !== 1'b0) bad++;
            end
            n_checks++;
            if (bad !== 0) begin
                n_fail++; $display("FAIL ign_restart: %0d busy cycles after DONE required 0", bad);
            end
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (outv[i] !== dat_a[i]) begin
                n_fail++; $display("FAIL ign_val%0d: got %h required %h", i, outv[i], dat_a[i]);
            end
            model_out[i] = dat_a[i];
        end
    endtask

    task automatic test_ack_race();
        int exp_done;
        exp_done = 1;
        for (int i = 0; i < 10; i++) lat_a[i] = int'($urandom_range(0, 3));
        lat_a[5] = TO - 1;
        for (int i = 0; i < 10; i++) exp_done += lat_a[i] + 2;
        for (int i = 0; i < 9; i++) dat_a[i] = 8'($urandom);
        run_seq(-1, 1'b0);
        n_checks++;
        if (error_to !== 1'b0 || done_count !== 1 || done_cycle !== exp_done) begin
            n_fail++; $display("FAIL race_done: err %b lista %0d at %0d required 0 1 %0d",
                               error_to, done_count, done_cycle, exp_done);
        end
        n_checks++;
        if (obs_len.size() !== 10 || obs_len[5] !== TO) begin
            n_fail++; $display("FAIL race_len: %0d bursts required 10 with burst 5 of %0d cycles",
                               obs_len.size(), TO);
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (outv[i] !== dat_a[i]) begin
                n_fail++; $display("FAIL race_val%0d: got %h required %h", i, outv[i], dat_a[i]);
            end
            model_out[i] = dat_a[i];
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit found;
        found = 1'b0;
        iniciar = 1'b1;
        for (cyc = 0; cyc < 100 && !found; cyc++) begin
            @(posedge clk); #1;
            iniciar = 1'b0; bus_if.bus_ack = 1'b0;
            if (bus_if.bus_req && bus_if.bus_addr == 8'h26) found = 1'b1;
            else if (bus_if.bus_req) begin bus_if.bus_ack = 1'b1; bus_if.Data_RD = 8'($urandom); end
        end
        bus_if.bus_ack = 1'b0;
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL mid_reach: read of 26 not seen within 100 cycles, required");
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus_if.bus_req, ocupado, lectura_lista, error_to} !== 4'b0000) begin
            n_fail++; $display("FAIL mid_async: req/ocup/lista/err=%b required 0000",
                               {bus_if.bus_req, ocupado, lectura_lista, error_to});
        end
        n_checks++;
        if (outv !== 72'h0) begin
            n_fail++; $display("FAIL mid_values: got %h required 0", outv);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) lat_a[i] = 0;
        for (int i = 0; i < 9; i++) dat_a[i] = 8'($urandom);
        run_seq(-1, 1'b0);
        n_checks++;
        if (obs_addr.size() !== 10 || obs_addr[0] !== 8'hF0 || done_cycle !== 21) begin
            n_fail++; $display("FAIL mid_rerun: %0d trans first %h lista at %0d required 10 F0 21",
                               obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 8'h00, done_cycle);
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (outv[i] !== dat_a[i]) begin
                n_fail++; $display("FAIL mid_val%0d: got %h required %h", i, outv[i], dat_a[i]);
            end
            model_out[i] = dat_a[i];
        end
    endtask

    task automatic test_random_reads();
        int exp_done;
        for (int r = 0; r < 3; r++) begin
            exp_done = 1;
            for (int i = 0; i < 10; i++) begin
                lat_a[i] = int'($urandom_range(0, TO - 2));
                exp_done += lat_a[i] + 2;
            end
            for (int i = 0; i < 9; i++) dat_a[i] = 8'($urandom);
            run_seq(-1, 1'b0);
            n_checks++;
            if (done_cycle !== exp_done || done_count !== 1 || error_to !== 1'b0) begin
                n_fail++; $display("FAIL rnd%0d_done: lista %0d at %0d err %b required 1 at %0d err 0",
                                   r, done_count, done_cycle, error_to, exp_done);
            end
            for (int i = 0; i < 9; i++) begin
                n_checks++;
                if (outv[i] !== dat_a[i]) begin
                    n_fail++; $display("FAIL rnd%0d_val%0d: got %h required %h", r, i, outv[i], dat_a[i]);
                end
                model_out[i] = dat_a[i];
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        iniciar = 1'b0;
        bus_if.bus_ack = 1'b0;
        bus_if.Data_RD = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_normal_read();
        test_stalled_ack();
        test_timeout();
        test_ignored_start();
        test_ack_race();
        test_reset_mid();
        test_random_reads();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lector_rtc.md
Name: lector_rtc

Overview:
- Read-side sequencer for the RTC parallel bus; counterpart of the write-data selector used for programming.
- On a start pulse it:
  - issues the RTC transfer command (address/data 8'hF0);
  - reads the nine time/date/timer registers in fixed order through the bus-cycle controller;
  - captures each byte into a shadow buffer;
  - commits all nine outputs at once when every read succeeds.
- Feeds the display/format logic. A timeout guards against a hung bus controller.

Parameters:
- TIMEOUT_CICLOS, 255: max cycles a single transaction waits in REQ for bus_ack before aborting (1..255).
- ADDR_CMD, 8'hF0: address and data used for the transfer command.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- iniciar  in  1  single-cycle start pulse; ignored while ocupado=1
- bus_ack  in  1  single-cycle pulse from bus controller: transaction finished
- Data_RD  in  8  read data from bus controller; valid only in the bus_ack cycle of a read
- bus_req  out  1  transaction request; level, held until bus_ack or timeout
- bus_wr  out  1  1=write (command transaction), 0=read; stable while bus_req=1
- bus_addr  out  8  RTC register address; stable while bus_req=1
- bus_dout  out  8  write data (ADDR_CMD during the command transaction, 0 otherwise)
- seg, min, hora, day, month, year, seg_t, min_t, hora_t  out  8 each  committed register values
- ocupado  out  1  high from the cycle after iniciar until return to IDLE
- lectura_lista  out  1  one-cycle pulse: new values committed
- error_to  out  1  sticky timeout flag; cleared on the next accepted iniciar

Behaviour:
- Reset: all outputs 0, shadow buffer 0, index 0, timer 0, state IDLE. Reset mid-sequence aborts immediately. No commit occurs, and bus_req drops asynchronously.
- Transaction index 0..9, in this order:
  - 0 = command: write, addr ADDR_CMD, data ADDR_CMD.
  - 1..9 = reads of seg 8'h21, min 8'h22, hora 8'h23, day 8'h24, month 8'h25, year 8'h26, seg_t 8'h42, min_t 8'h41, hora_t 8'h43.
- IDLE: bus_req=0, ocupado=0. iniciar=1 → REQ, index=0, error_to cleared.
- REQ:
  - bus_req=1, with bus_wr/bus_addr/bus_dout driven from the index.
  - Timer increments each cycle without ack.
  - bus_ack=1 → read index stores Data_RD into shadow[index-1]; go to GAP; timer cleared.
  - Timer reaches TIMEOUT_CICLOS-1 with no ack → error_to=1, bus_req=0, go to IDLE. The shadow buffer is discarded and outputs keep their previous committed values.
- GAP:
  - One cycle with bus_req=0 (mandatory inter-transaction idle).
  - index<9 → index+1, go to REQ.
  - index=9 → copy all shadow bytes to outputs at this edge, go to DONE.
- DONE: lectura_lista=1 for exactly one cycle, ocupado=1, then IDLE.
- Timing: each transaction costs L+2 cycles, where L = REQ cycles before ack (ack in first REQ cycle → L=0). With L=0, lectura_lista is high in cycle 21 counting iniciar's cycle as 0.
- Edge cases:
  - bus_ack outside REQ is ignored.
  - bus_ack coinciding with the timeout cycle counts as success (ack wins).
  - iniciar during ocupado is ignored (no queuing).
  - iniciar in the DONE cycle is ignored.
- Output bytes are raw BCD as read; no arithmetic or reformatting.

Decomposition:
- Shared package/include holds:
  - RTC address constants (ADDR_SEG..ADDR_HORA_T, ADDR_CMD);
  - state encoding (IDLE, REQ, GAP, DONE);
  - N_TRANS=10.
- One natural sub-module: tabla_dir_rtc, a combinational index→{bus_wr, bus_addr, bus_dout} lookup shared with the programming path.

Test Plan:
- Normal read:
  - Stimulus: ack every transaction with L=0; Data_RD = 8'h11..8'h99 on reads 1..9.
  - Required: seg=8'h11 … hora_t=8'h99; lectura_lista pulses in cycle 21; observed bus_addr sequence F0,21,22,23,24,25,26,42,41,43 with bus_wr=1 only on F0.
- Stalled ack:
  - Stimulus: L=5 on every transaction.
  - Required: lectura_lista in cycle 71; bus_req stays high 6 cycles per transaction with stable address.
- Timeout:
  - Stimulus: a previous full read committed seg=8'h30; no ack on read 4 (day), TIMEOUT_CICLOS=8.
  - Required: bus_req drops after 8 REQ cycles; error_to=1; no lectura_lista; seg still 8'h30.
  - Follow-up: a subsequent iniciar clears error_to.
- Ignored start:
  - Stimulus: iniciar pulses during REQ, during GAP and in the DONE cycle.
  - Required: no restart and no second lectura_lista; address sequence unchanged.
- Reset mid-operation:
  - Stimulus: assert reset during REQ of read 6.
  - Required: bus_req=0 immediately (asynchronously); all outputs 0, ocupado=0.
  - Follow-up: a new iniciar after release runs the full sequence from F0.
- Ack race:
  - Stimulus: bus_ack arrives exactly on the timeout cycle.
  - Required: treated as success; data captured; sequence continues; error_to=0.
